// File: rtl/aes_result_sequencer_pkg.sv
// Shared types and helpers for the AES result sequencer.
// Holds the FSM state enum, mode codes and the per-mode latency lookup.
package aes_disp_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        SHOW
    } state_t;

    localparam logic [1:0] MODE_128 = 2'd0;
    localparam logic [1:0] MODE_192 = 2'd1;
    localparam logic [1:0] MODE_256 = 2'd2;

    // Mode 3 is not a real key size; it runs with the AES-128 latency.
    function automatic int lat_of(
        input logic [1:0] mode,
        input int         l0,
        input int         l1,
        input int         l2
    );
        case (mode)
            MODE_192: return l1;
            MODE_256: return l2;
            default:  return l0;
        endcase
    endfunction

endpackage

// File: rtl/aes_result_sequencer_if.sv
// Bus bundle between the AES self-test top and the result sequencer.
// master drives the AES data and user controls, slave returns the display.
interface aes_result_sequencer_if #(
    parameter int BLOCK_SIZE = 128,
    parameter int VIEW_BYTES = 2
);
    import aes_disp_pkg::*;

    localparam int NWIN = BLOCK_SIZE / (8 * VIEW_BYTES);
    localparam int IW   = (NWIN > 1) ? $clog2(NWIN) : 1;

    logic [1:0]              mode_sel;
    logic                    start;
    logic                    step;
    logic [BLOCK_SIZE-1:0]   enc_data;
    logic [BLOCK_SIZE-1:0]   dec_data;
    logic [BLOCK_SIZE-1:0]   exp_enc;
    logic [BLOCK_SIZE-1:0]   plain_ref;
    logic [8*VIEW_BYTES-1:0] view_byte;
    logic [IW-1:0]           view_index;
    logic                    phase;
    logic                    busy;
    logic                    done;
    logic                    enc_ok;
    logic                    dec_ok;

    modport master (
        output mode_sel, start, step,
        output enc_data, dec_data, exp_enc, plain_ref,
        input  view_byte, view_index, phase,
        input  busy, done, enc_ok, dec_ok
    );

    modport slave (
        input  mode_sel, start, step,
        input  enc_data, dec_data, exp_enc, plain_ref,
        output view_byte, view_index, phase,
        output busy, done, enc_ok, dec_ok
    );

endinterface

// File: rtl/aes_result_sequencer_window_mux.sv
// Combinational window selector: picks window i_idx of the cipher or
// recovered-plaintext block; window 0 is the least significant bytes.
module aes_byte_window_mux
    import aes_disp_pkg::*;
#(
    parameter int BLOCK_SIZE = 128,
    parameter int VIEW_BYTES = 2,
    parameter int IW         = 3
) (
    input  logic [BLOCK_SIZE-1:0]   i_enc,
    input  logic [BLOCK_SIZE-1:0]   i_dec,
    input  logic [IW-1:0]           i_idx,
    input  logic                    i_phase,
    output logic [8*VIEW_BYTES-1:0] o_win
);
    localparam int VW = 8 * VIEW_BYTES;

    logic [BLOCK_SIZE-1:0] w_src;

    assign w_src = i_phase ? i_dec : i_enc;
    assign o_win = w_src[i_idx*VW +: VW];

endmodule

// File: rtl/aes_result_sequencer.sv
// Run controller and paged result viewer for the AES self-test.
// Optional macro AES_RESULT_SEQUENCER_AUTO_STEP_EN adds a periodic auto-step.
module aes_result_sequencer
    import aes_disp_pkg::*;
#(
    parameter int BLOCK_SIZE  = 128,
    parameter int VIEW_BYTES  = 2,
    parameter int LAT_0       = 12,
    parameter int LAT_1       = 14,
    parameter int LAT_2       = 16,
    parameter int CNT_W       = 6,
    parameter int AUTO_PERIOD = 50000000
) (
    input logic                   clk,
    input logic                   reset_n,
    aes_result_sequencer_if.slave bus
);
    localparam int VW   = 8 * VIEW_BYTES;
    localparam int NWIN = BLOCK_SIZE / VW;
    localparam int IW   = (NWIN > 1) ? $clog2(NWIN) : 1;
    localparam int LMAX = (LAT_0 > LAT_1) ?
                          ((LAT_0 > LAT_2) ? LAT_0 : LAT_2) :
                          ((LAT_1 > LAT_2) ? LAT_1 : LAT_2);

    if (((BLOCK_SIZE / 8) % VIEW_BYTES) != 0 ||
        (2 * LMAX) >= (1 << CNT_W) || AUTO_PERIOD < 1) begin : g_bad_cfg
        $error("aes_result_sequencer: inconsistent parameters");
    end

    state_t          r_state;
    logic [1:0]      r_mode;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_lat1;
    logic [CNT_W-1:0] r_lat2;
    logic            r_start_d;
    logic            r_step_d;
    logic [VW-1:0]   r_view_byte;
    logic [IW-1:0]   r_view_index;
    logic            r_phase;
    logic            r_busy;
    logic            r_done;
    logic            r_enc_ok;
    logic            r_dec_ok;

    logic            w_start;
    logic            w_step_man;
    logic            w_auto;
    logic            w_step;
    logic            w_abort;
    logic            w_go;
    logic [IW-1:0]   w_nxt_idx;
    logic            w_nxt_phase;
    logic [VW-1:0]   w_win;
    int              w_lat;

    assign w_start    = bus.start & ~r_start_d;
    assign w_step_man = bus.step & ~r_step_d;
    assign w_step     = w_step_man | w_auto;
    assign w_abort    = (r_state != IDLE) && (bus.mode_sel != r_mode);
    assign w_go       = w_start && (r_state != WAIT);
    assign w_lat      = lat_of(bus.mode_sel, LAT_0, LAT_1, LAT_2);

`ifdef AES_RESULT_SEQUENCER_AUTO_STEP_EN
    localparam int AW = (AUTO_PERIOD > 1) ? $clog2(AUTO_PERIOD) : 1;

    logic [AW-1:0] r_auto;

    assign w_auto = (r_state == SHOW) && (r_auto == AW'(AUTO_PERIOD - 1));

    // Auto-step timer: runs only in SHOW, restarts on any step.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_auto <= '0;
        end else if (r_state != SHOW || w_step_man || w_auto) begin
            r_auto <= '0;
        end else begin
            r_auto <= r_auto + 1'b1;
        end
    end
`else
    assign w_auto = 1'b0;
`endif

    // Next window position: reset to 0 while waiting, advance on a step in SHOW.
    always_comb begin
        w_nxt_idx   = r_view_index;
        w_nxt_phase = r_phase;
        if (r_state == WAIT) begin
            w_nxt_idx   = '0;
            w_nxt_phase = 1'b0;
        end else if (r_state == SHOW && w_step) begin
            if (r_view_index == IW'(NWIN - 1)) begin
                w_nxt_idx   = '0;
                w_nxt_phase = ~r_phase;
            end else begin
                w_nxt_idx = r_view_index + 1'b1;
            end
        end
    end

    aes_byte_window_mux #(
        .BLOCK_SIZE (BLOCK_SIZE),
        .VIEW_BYTES (VIEW_BYTES),
        .IW         (IW)
    ) u_mux (
        .i_enc   (bus.enc_data),
        .i_dec   (bus.dec_data),
        .i_idx   (w_nxt_idx),
        .i_phase (w_nxt_phase),
        .o_win   (w_win)
    );

    // Control FSM with registered outputs: start, wait/check, then paging.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= IDLE;
            r_mode       <= '0;
            r_cnt        <= '0;
            r_lat1       <= '0;
            r_lat2       <= '0;
            r_start_d    <= 1'b0;
            r_step_d     <= 1'b0;
            r_view_byte  <= '0;
            r_view_index <= '0;
            r_phase      <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_enc_ok     <= 1'b0;
            r_dec_ok     <= 1'b0;
        end else begin
            r_start_d <= bus.start;
            r_step_d  <= bus.step;
            if (w_abort) begin
                r_state     <= IDLE;
                r_busy      <= 1'b0;
                r_done      <= 1'b0;
                r_enc_ok    <= 1'b0;
                r_dec_ok    <= 1'b0;
                r_view_byte <= '0;
            end else if (w_go) begin
                r_state  <= WAIT;
                r_mode   <= bus.mode_sel;
                r_lat1   <= CNT_W'(w_lat - 1);
                r_lat2   <= CNT_W'(2 * w_lat - 1);
                r_cnt    <= '0;
                r_busy   <= 1'b1;
                r_done   <= 1'b0;
                r_enc_ok <= 1'b0;
                r_dec_ok <= 1'b0;
            end else begin
                unique case (r_state)
                    IDLE: ;
                    WAIT: begin
                        r_cnt <= r_cnt + 1'b1;
                        if (r_cnt == r_lat1) begin
                            r_enc_ok <= (bus.enc_data == bus.exp_enc);
                        end
                        if (r_cnt == r_lat2) begin
                            r_dec_ok     <= (bus.dec_data == bus.plain_ref);
                            r_done       <= 1'b1;
                            r_busy       <= 1'b0;
                            r_view_index <= '0;
                            r_phase      <= 1'b0;
                            r_view_byte  <= w_win;
                            r_state      <= SHOW;
                        end
                    end
                    SHOW: begin
                        r_view_index <= w_nxt_idx;
                        r_phase      <= w_nxt_phase;
                        r_view_byte  <= w_win;
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

    assign bus.view_byte  = r_view_byte;
    assign bus.view_index = r_view_index;
    assign bus.phase      = r_phase;
    assign bus.busy       = r_busy;
    assign bus.done       = r_done;
    assign bus.enc_ok     = r_enc_ok;
    assign bus.dec_ok     = r_dec_ok;

endmodule
